player_physics_engine: RTL and testbench

- Per-player kinematics core for the fighter game. It owns one player's sprite position and vertical velocity, and updates them once per game tick.
- Successor to the fixed 20 Hz engine, with these changes:
  - an external tick strobe replaces the internal clock divider;
  - arena, jump and gravity constants are parameters;
  - signed velocity arithmetic with saturation;
  - the player can stand on the opponent;
  - a timed knockback mode.
- Sits between the input decoder / collision detector and the sprite renderer. There is one instance per player.

---
 rtl/phys_pkg.sv | 21 ++
 rtl/knockback_timer.sv | 52 +++++
 rtl/player_physics_engine.sv | 151 +++++++++++++++
 tb/tb_player_physics_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/phys_pkg.sv
// Shared definitions for the player kinematics core: vertical state encoding,
// default arena geometry and the clamping adder used for both axes.
package phys_pkg;

  typedef enum logic {GROUND = 1'b0, AIR = 1'b1} vstate_t;

  localparam int ARENA_X_MIN   = 15;
  localparam int ARENA_X_MAX   = 75;
  localparam int ARENA_FLOOR_Y = 48;
  localparam int ARENA_CEIL_Y  = 4;

  // Add in full int precision, then clamp, so no intermediate value can wrap.
  function automatic int sat_add(int a, int b, int lo, int hi);
    int s;
    s = a + b;
    if (s < lo) return lo;
    if (s > hi) return hi;
    return s;
  endfunction

endpackage

// File: rtl/knockback_timer.sv
// Knockback request latch and duration counter. A pulse is held until the next
// game tick, which consumes it and starts (or restarts) the knockback window.
module knockback_timer #(
  parameter int KNOCK_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic knock,
  input  logic knock_dir,
  output logic active,
  output logic dir,
  output logic consume
);

  localparam int CW = $clog2(KNOCK_TICKS + 1);

  logic          pend_q;
  logic          pend_dir_q;
  logic          dir_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (knock) begin
        pend_q     <= 1'b1;
        pend_dir_q <= knock_dir;
      end else if (tick) begin
        pend_q <= 1'b0;
      end
      // The consuming tick counts as the first of the KNOCK_TICKS moves.
      if (tick) begin
        if (pend_q) begin
          cnt_q <= CW'(KNOCK_TICKS - 1);
          dir_q <= pend_dir_q;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign consume = tick & pend_q;
  assign active  = (cnt_q != '0);
  assign dir     = pend_q ? pend_dir_q : dir_q;

endmodule

// File: rtl/player_physics_engine.sv
// One player's position and vertical velocity, advanced once per game tick:
// walk/knockback horizontally, jump/fall/land vertically.
module player_physics_engine
  import phys_pkg::*;
#(
  parameter int PLAYER_NO   = 0,
  parameter int X_W         = 7,
  parameter int Y_W         = 7,
  parameter int X_MIN       = ARENA_X_MIN,
  parameter int X_MAX       = ARENA_X_MAX,
  parameter int FLOOR_Y     = ARENA_FLOOR_Y,
  parameter int CEIL_Y      = ARENA_CEIL_Y,
  parameter int WALK_STEP   = 2,
  parameter int JUMP_VEL    = 8,
  parameter int GRAVITY     = 1,
  parameter int VMAX_DOWN   = 15,
  parameter int SPRITE_H    = 20,
  parameter int KNOCK_STEP  = 3,
  parameter int KNOCK_TICKS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           jump,
  input  logic           colliding,
  input  logic [X_W-1:0] opp_x,
  input  logic [Y_W-1:0] opp_y,
  input  logic           knock,
  input  logic           knock_dir,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [Y_W:0]   vel_y,
  output logic           airborne,
  output logic           knocked,
  output logic           landed
);

  localparam int VW = Y_W + 1;

  vstate_t               state_q;
  logic    [X_W-1:0]     x_q;
  logic    [Y_W-1:0]     y_q;
  logic signed [Y_W:0]   vy_q;
  logic                  landed_q;

  logic kn_active;
  logic kn_dir;
  logic kn_consume;

  knockback_timer #(
    .KNOCK_TICKS(KNOCK_TICKS)
  ) u_knock (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .knock    (knock),
    .knock_dir(knock_dir),
    .active   (kn_active),
    .dir      (kn_dir),
    .consume  (kn_consume)
  );

  int dx;
  int x_n;
  int y_c;
  int v_c;
  int y_n;
  int v_n;
  int perch;
  int jump_y;

  always_comb begin
    dx = 0;
    if (kn_active || kn_consume) begin
      dx = kn_dir ? KNOCK_STEP : -KNOCK_STEP;
    end else if (move_left && !move_right && !(colliding && x_q > opp_x)) begin
      dx = -WALK_STEP;
    end else if (move_right && !move_left && !(colliding && x_q < opp_x)) begin
      dx = WALK_STEP;
    end
    x_n = sat_add(int'(x_q), dx, X_MIN, X_MAX);

    y_c    = int'(y_q);
    v_c    = int'(vy_q);
    y_n    = y_c + v_c;
    v_n    = v_c + GRAVITY;
    if (v_n > VMAX_DOWN) v_n = VMAX_DOWN;
    perch  = sat_add(int'(opp_y), -SPRITE_H, CEIL_Y, FLOOR_Y);
    jump_y = sat_add(y_c, -JUMP_VEL, CEIL_Y, FLOOR_Y);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= X_W'((PLAYER_NO != 0) ? X_MAX : X_MIN);
      y_q      <= Y_W'(FLOOR_Y);
      vy_q     <= '0;
      state_q  <= GROUND;
      landed_q <= 1'b0;
    end else begin
      landed_q <= 1'b0;
      if (tick) begin
        x_q <= X_W'(x_n);
        case (state_q)
          GROUND: begin
            if (jump) begin
              y_q     <= Y_W'(jump_y);
              vy_q    <= VW'(GRAVITY - JUMP_VEL);
              state_q <= AIR;
            end else if (y_c != FLOOR_Y && !colliding) begin
              // Stepped off the opponent's head: start falling from rest.
              vy_q    <= '0;
              state_q <= AIR;
            end else begin
              vy_q <= '0;
            end
          end
          AIR: begin
            if (y_n >= FLOOR_Y) begin
              y_q      <= Y_W'(FLOOR_Y);
              vy_q     <= '0;
              state_q  <= GROUND;
              landed_q <= 1'b1;
            end else if (colliding && v_c > 0 && y_n >= perch) begin
              y_q      <= Y_W'(perch);
              vy_q     <= '0;
              state_q  <= GROUND;
              landed_q <= 1'b1;
            end else if (y_n <= CEIL_Y) begin
              y_q  <= Y_W'(CEIL_Y);
              vy_q <= '0;
            end else begin
              y_q  <= Y_W'(y_n);
              vy_q <= VW'(v_n);
            end
          end
          default: state_q <= GROUND;
        endcase
      end
    end
  end

  assign pos_x    = x_q;
  assign pos_y    = y_q;
  assign vel_y    = vy_q;
  assign airborne = (state_q == AIR);
  assign knocked  = kn_active;
  assign landed   = landed_q;

endmodule

// File: tb/tb_player_physics_engine.sv
// Directed bench: each tick pushes its hand-computed expected outputs into a
// scoreboard queue; a monitor pops and compares after every tick edge.
module tb_player_physics_engine;

  localparam int DC = 999;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       jump = 1'b0;
  logic       colliding = 1'b0;
  logic [6:0] opp_x = 7'd40;
  logic [6:0] opp_y = 7'd48;
  logic       knock = 1'b0;
  logic       knock_dir = 1'b0;

  logic [6:0] pos_x0, pos_y0, pos_x1, pos_y1;
  logic [7:0] vel_y0, vel_y1;
  logic       air0, air1, kn0, kn1, ld0, ld1;

  player_physics_engine #(.PLAYER_NO(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .move_left(move_left), .move_right(move_right),
    .jump(jump), .colliding(colliding), .opp_x(opp_x), .opp_y(opp_y), .knock(knock),
    .knock_dir(knock_dir), .pos_x(pos_x0), .pos_y(pos_y0), .vel_y(vel_y0), .airborne(air0),
    .knocked(kn0), .landed(ld0)
  );

  player_physics_engine #(.PLAYER_NO(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .move_left(move_left), .move_right(move_right),
    .jump(jump), .colliding(colliding), .opp_x(opp_x), .opp_y(opp_y), .knock(knock),
    .knock_dir(knock_dir), .pos_x(pos_x1), .pos_y(pos_y1), .vel_y(vel_y1), .airborne(air1),
    .knocked(kn1), .landed(ld1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    vy;
    int    air;
    int    kn;
    int    ld;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  int jy[17] = '{40, 33, 27, 22, 18, 15, 13, 12, 12, 13, 15, 18, 22, 27, 33, 40, 48};
  int jv[17] = '{-7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
  int fy[7]  = '{28, 29, 31, 34, 38, 43, 48};
  int fv[7]  = '{1, 2, 3, 4, 5, 6, 0};

  task automatic chk(string name, int act, int exp);
    if (exp == DC) return;
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(string nm, int x, int y, int vy, int air, int kn, int ld);
    exp_t e;
    e.name = nm; e.x = x; e.y = y; e.vy = vy; e.air = air; e.kn = kn; e.ld = ld;
    sb.push_back(e);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_knock(logic d);
    @(negedge clk);
    knock = 1'b1;
    knock_dir = d;
    @(negedge clk);
    knock = 1'b0;
  endtask

  // Monitor: after every tick edge compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (tick && reset) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: got tick with empty scoreboard expected none");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_x"}, int'(pos_x0), e.x);
          chk({e.name, "_y"}, int'(pos_y0), e.y);
          chk({e.name, "_vy"}, int'($signed(vel_y0)), e.vy);
          chk({e.name, "_air"}, int'(air0), e.air);
          chk({e.name, "_knocked"}, int'(kn0), e.kn);
          chk({e.name, "_landed"}, int'(ld0), e.ld);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk("rst1_x", int'(pos_x1), 75);
    chk("rst1_y", int'(pos_y1), 48);
    chk("rst1_vy", int'($signed(vel_y1)), 0);
    chk("rst1_air", int'(air1), 0);
    chk("rst0_x", int'(pos_x0), 15);
    chk("rst0_knocked", int'(kn0), 0);
    chk("rst0_landed", int'(ld0), 0);
    @(negedge clk);
    reset = 1'b1;

    // Walk right into the wall, then both directions at once.
    move_right = 1'b1;
    for (int k = 1; k <= 40; k++)
      step($sformatf("walk%0d", k), (15 + 2 * k > 75) ? 75 : 15 + 2 * k, 48, 0, 0, 0, 0);
    move_left = 1'b1;
    for (int k = 0; k < 3; k++) step($sformatf("both%0d", k), 75, 48, 0, 0, 0, 0);
    move_left = 1'b0;
    move_right = 1'b0;

    // Single-tick jump, full arc back to the floor.
    jump = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step($sformatf("jump%0d", i), 75, jy[i], jv[i], (i < 16) ? 1 : 0, 0, (i == 16) ? 1 : 0);
      jump = 1'b0;
    end
    @(negedge clk);
    chk("landed_clear", int'(ld0), 0);

    // Land on the opponent's head, then walk off and fall.
    colliding = 1'b1;
    jump = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step($sformatf("hop%0d", i), 75, jy[i], jv[i], 1, 0, 0);
      jump = 1'b0;
    end
    step("perch", 75, 28, 0, 0, 0, 1);
    colliding = 1'b0;
    step("walkoff", 75, 28, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      step($sformatf("fall%0d", i), 75, fy[i], fv[i], (i < 6) ? 1 : 0, 0, (i == 6) ? 1 : 0);

    // Knockback left with walk-right ignored; re-knock extends; last pulse's dir wins.
    move_right = 1'b1;
    pulse_knock(1'b0);
    step("kb1", 72, 48, 0, 0, 1, 0);
    pulse_knock(1'b1);
    pulse_knock(1'b0);
    step("kb2", 69, 48, 0, 0, 1, 0);
    step("kb3", 66, 48, 0, 0, 1, 0);
    step("kb4", 63, 48, 0, 0, 1, 0);
    step("kb5", 60, 48, 0, 0, 0, 0);
    step("kb_walk", 62, 48, 0, 0, 0, 0);
    move_right = 1'b0;
    move_left = 1'b1;
    for (int k = 1; k <= 21; k++) step($sformatf("left%0d", k), 62 - 2 * k, 48, 0, 0, 0, 0);
    move_left = 1'b0;
    move_right = 1'b1;
    pulse_knock(1'b0);
    step("kw1", 17, 48, 0, 0, 1, 0);
    step("kw2", 15, 48, 0, 0, 1, 0);
    step("kw3", 15, 48, 0, 0, 1, 0);
    step("kw4", 15, 48, 0, 0, 0, 0);
    step("kw_walk", 17, 48, 0, 0, 0, 0);

    // No tick for 1000 clocks: everything holds, the knock stays latched.
    move_left = 1'b1;
    jump = 1'b1;
    colliding = 1'b1;
    repeat (500) @(negedge clk);
    pulse_knock(1'b1);
    repeat (500) @(negedge clk);
    chk("idle_x", int'(pos_x0), 17);
    chk("idle_y", int'(pos_y0), 48);
    chk("idle_vy", int'($signed(vel_y0)), 0);
    chk("idle_air", int'(air0), 0);
    chk("idle_knocked", int'(kn0), 0);
    step("all_in", 20, 40, -7, 1, 1, 0);
    chk("pre_rst1_air", int'(air1), 1);

    // Asynchronous reset mid-air and mid-knockback, no clock edge needed.
    #2;
    reset = 1'b0;
    #1;
    chk("arst0_x", int'(pos_x0), 15);
    chk("arst0_y", int'(pos_y0), 48);
    chk("arst0_vy", int'($signed(vel_y0)), 0);
    chk("arst0_air", int'(air0), 0);
    chk("arst0_knocked", int'(kn0), 0);
    chk("arst1_x", int'(pos_x1), 75);
    chk("arst1_y", int'(pos_y1), 48);
    chk("arst1_vy", int'($signed(vel_y1)), 0);
    chk("arst1_air", int'(air1), 0);
    move_left = 1'b0;
    move_right = 1'b0;
    jump = 1'b0;
    colliding = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
